i2s_stereo_gain: RTL and testbench

//  Per-channel gain/mute stage between the I2S PMOD ADC stream outputs and the DAC stream inputs.

---
 rtl/i2s_stereo_gain_pkg.sv | 34 +++
 rtl/i2s_stereo_gain_lane.sv | 112 +++++++++++
 rtl/i2s_stereo_gain.sv | 52 +++++
 tb/tb_i2s_stereo_gain.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_stereo_gain_pkg.sv
// Shared constants, ramp state encoding and output saturation for the
// stereo gain stage.
package i2s_stereo_gain_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int GAIN_WIDTH = 16;
  localparam int GAIN_FRAC  = 14;
  localparam int GAIN_UNITY = 1 << GAIN_FRAC;
  localparam int NUM_LANES  = 2;

  // Full signed product, plus one guard bit so the rounding add cannot wrap.
  localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH;
  localparam int SUM_WIDTH  = PROD_WIDTH + 1;

  typedef enum logic [1:0] {
    RAMP_IDLE = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

  // Clamp a wide signed value into the sample range. The value fits when all
  // bits from the sample MSB upward are copies of the sign bit.
  function automatic logic [DATA_WIDTH-1:0] sat_data(input logic signed [SUM_WIDTH-1:0] x);
    logic [SUM_WIDTH-DATA_WIDTH:0] hi;
    hi = x[SUM_WIDTH-1:DATA_WIDTH-1];
    if ((&hi) || (~|hi))
      return x[DATA_WIDTH-1:0];
    else if (x[SUM_WIDTH-1])
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/i2s_stereo_gain_lane.sv
// One audio channel: 2-stage multiply / round-saturate pipeline with a
// valid/ready handshake and a rate-limited gain ramp toward the target.
module i2s_gain_lane
  import i2s_stereo_gain_pkg::*;
#(
  parameter int                    RAMP_STEP = 16,
  parameter logic [GAIN_WIDTH-1:0] GAIN_INIT = GAIN_WIDTH'(GAIN_UNITY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  input  logic [GAIN_WIDTH-1:0] gain_i,
  input  logic                  gain_load_i,
  input  logic                  mute_i
);

  localparam int STAGES = 2;
  localparam logic signed [GAIN_WIDTH-1:0] STEP_G  = GAIN_WIDTH'(RAMP_STEP);
  localparam logic signed [GAIN_WIDTH:0]   STEP_S  = (GAIN_WIDTH+1)'(RAMP_STEP);
  localparam logic signed [GAIN_WIDTH:0]   NSTEP_S = -STEP_S;
  localparam logic signed [SUM_WIDTH-1:0]  ROUND_ADD = SUM_WIDTH'(1) << (GAIN_FRAC-1);

  logic                         adv, acc;
  logic [STAGES:1]              vld_q;
  logic signed [PROD_WIDTH-1:0] prod_d, prod_q;
  logic signed [SUM_WIDTH-1:0]  rnd_sum, rnd_shr;
  logic [DATA_WIDTH-1:0]        out_d, out_q;

  logic signed [GAIN_WIDTH-1:0] gain_cur_q, cap_q, tgt;
  logic signed [GAIN_WIDTH-1:0] gain_up_d, gain_dn_d;
  logic signed [GAIN_WIDTH:0]   diff;
  logic                         tgt_gt, tgt_lt, far_up, far_dn;
  ramp_state_e                  state_q;

  // Whole pipe advances unless the output slot is full and blocked.
  assign adv        = !vld_q[STAGES] | m_tready_i;
  assign s_tready_o = adv & !rst;
  assign acc        = s_tvalid_i & s_tready_o;

  assign prod_d  = $signed({{GAIN_WIDTH{s_tdata_i[DATA_WIDTH-1]}}, s_tdata_i}) *
                   $signed({{DATA_WIDTH{gain_cur_q[GAIN_WIDTH-1]}}, gain_cur_q});
  assign rnd_sum = $signed({prod_q[PROD_WIDTH-1], prod_q}) + ROUND_ADD;
  assign rnd_shr = rnd_sum >>> GAIN_FRAC;
  assign out_d   = sat_data(rnd_shr);

  assign m_tvalid_o = vld_q[STAGES] & !rst;
  assign m_tdata_o  = rst ? '0 : out_q;

  // Product stage and round/saturate stage, both held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      prod_q <= '0;
      out_q  <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[STAGES-1:1], acc};
      if (acc)      prod_q <= prod_d;
      if (vld_q[1]) out_q  <= out_d;
    end
  end

  // Ramp arithmetic: step by RAMP_STEP when far, otherwise land exactly on target.
  assign tgt       = mute_i ? '0 : cap_q;
  assign diff      = $signed({tgt[GAIN_WIDTH-1], tgt}) -
                     $signed({gain_cur_q[GAIN_WIDTH-1], gain_cur_q});
  assign tgt_lt    = diff[GAIN_WIDTH];
  assign tgt_gt    = !diff[GAIN_WIDTH] && (diff != '0);
  assign far_up    = diff > STEP_S;
  assign far_dn    = diff < NSTEP_S;
  assign gain_up_d = far_up ? gain_cur_q + STEP_G : tgt;
  assign gain_dn_d = far_dn ? gain_cur_q - STEP_G : tgt;

  // Ramp FSM: direction picked one cycle after the target moves, gain steps on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RAMP_IDLE;
      gain_cur_q <= GAIN_INIT;
      cap_q      <= GAIN_INIT;
    end else begin
      if (gain_load_i) cap_q <= gain_i;
      case (state_q)
        RAMP_IDLE: begin
          if (tgt_gt)      state_q <= RAMP_UP;
          else if (tgt_lt) state_q <= RAMP_DOWN;
        end
        RAMP_UP: begin
          if (!tgt_gt && !tgt_lt) state_q <= RAMP_IDLE;
          else if (tgt_lt)        state_q <= RAMP_DOWN;
          else if (acc) begin
            gain_cur_q <= gain_up_d;
            if (!far_up) state_q <= RAMP_IDLE;
          end
        end
        RAMP_DOWN: begin
          if (!tgt_gt && !tgt_lt) state_q <= RAMP_IDLE;
          else if (tgt_gt)        state_q <= RAMP_UP;
          else if (acc) begin
            gain_cur_q <= gain_dn_d;
            if (!far_dn) state_q <= RAMP_IDLE;
          end
        end
        default: state_q <= RAMP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i2s_stereo_gain.sv
// Stereo gain/mute stage between the ADC and DAC sample streams: two
// independent lanes sharing only the gain-load strobe and the mute level.
module i2s_stereo_gain
  import i2s_stereo_gain_pkg::*;
#(
  parameter int                    RAMP_STEP = 16,
  parameter logic [GAIN_WIDTH-1:0] GAIN_INIT = GAIN_WIDTH'(GAIN_UNITY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_l_tdata,
  input  logic [DATA_WIDTH-1:0] s_r_tdata,
  input  logic [1:0]            s_tvalid,
  output logic [1:0]            s_tready,
  output logic [DATA_WIDTH-1:0] m_l_tdata,
  output logic [DATA_WIDTH-1:0] m_r_tdata,
  output logic [1:0]            m_tvalid,
  input  logic [1:0]            m_tready,
  input  logic [GAIN_WIDTH-1:0] gain_l,
  input  logic [GAIN_WIDTH-1:0] gain_r,
  input  logic                  gain_load,
  input  logic                  mute
);

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] s_data, m_data;
  logic [NUM_LANES-1:0][GAIN_WIDTH-1:0] gain;

  assign s_data    = {s_r_tdata, s_l_tdata};
  assign gain      = {gain_r, gain_l};
  assign m_l_tdata = m_data[0];
  assign m_r_tdata = m_data[1];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    i2s_gain_lane #(
      .RAMP_STEP (RAMP_STEP),
      .GAIN_INIT (GAIN_INIT)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .s_tdata_i   (s_data[i]),
      .s_tvalid_i  (s_tvalid[i]),
      .s_tready_o  (s_tready[i]),
      .m_tdata_o   (m_data[i]),
      .m_tvalid_o  (m_tvalid[i]),
      .m_tready_i  (m_tready[i]),
      .gain_i      (gain[i]),
      .gain_load_i (gain_load),
      .mute_i      (mute)
    );
  end

endmodule

// File: tb/tb_i2s_stereo_gain.sv
// Scoreboard bench for i2s_stereo_gain: expected samples are queued at
// accept time from a reference gain model and compared when the DUT emits.
module tb_i2s_stereo_gain;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_l_tdata, s_r_tdata, m_l_tdata, m_r_tdata;
  logic [1:0]  s_tvalid, s_tready, m_tvalid, m_tready;
  logic [15:0] gain_l, gain_r;
  logic        gain_load, mute;

  i2s_stereo_gain dut (
    .clk(clk), .rst(rst),
    .s_l_tdata(s_l_tdata), .s_r_tdata(s_r_tdata),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_l_tdata(m_l_tdata), .m_r_tdata(m_r_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .gain_l(gain_l), .gain_r(gain_r),
    .gain_load(gain_load), .mute(mute)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] exp_l[$];
  logic [31:0] exp_r[$];
  int          gm[2];
  int          cap[2];
  bit          ovr_v[2];
  logic [31:0] ovr_d[2];
  bit          hold_v[2];
  logic [31:0] hold_d[2];

  function automatic logic [31:0] ref_out(logic [31:0] s, int g);
    longint p;
    p = longint'($signed(s)) * longint'(g);
    p = (p + 64'sd8192) >>> 14;
    if (p > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
    return p[31:0];
  endfunction

  function automatic int tgt_of(int i);
    return mute ? 0 : cap[i];
  endfunction

  function automatic void step_model(int i);
    int t;
    t = tgt_of(i);
    if (t > gm[i])      gm[i] += (t - gm[i] > 16) ? 16 : t - gm[i];
    else if (t < gm[i]) gm[i] -= (gm[i] - t > 16) ? 16 : gm[i] - t;
  endfunction

  // One clock: check held outputs, pop/compare emitted samples, push accepted ones.
  task automatic cycle();
    logic [31:0] sd, md, e;
    #1;
    for (int i = 0; i < 2; i++) begin
      sd = (i == 0) ? s_l_tdata : s_r_tdata;
      md = (i == 0) ? m_l_tdata : m_r_tdata;
      if (hold_v[i]) begin
        n_cmp++;
        if (m_tvalid[i] !== 1'b1 || md !== hold_d[i]) begin
          n_mis++;
          $display("FAIL hold_lane%0d: valid=%b data=%h, required valid=1 data=%h", i, m_tvalid[i], md, hold_d[i]);
        end
      end
      hold_v[i] = m_tvalid[i] & !m_tready[i];
      hold_d[i] = md;
      if (m_tvalid[i] && m_tready[i]) begin
        n_cmp++;
        if ((i == 0 ? exp_l.size() : exp_r.size()) == 0) begin
          n_mis++;
          $display("FAIL out_lane%0d: got %h, no sample expected", i, md);
        end else begin
          e = (i == 0) ? exp_l.pop_front() : exp_r.pop_front();
          if (md !== e) begin
            n_mis++;
            $display("FAIL out_lane%0d: got %h, expected %h", i, md, e);
          end
        end
      end
      if (s_tvalid[i] && s_tready[i]) begin
        e = ovr_v[i] ? ovr_d[i] : ref_out(sd, gm[i]);
        ovr_v[i] = 1'b0;
        if (i == 0) exp_l.push_back(e); else exp_r.push_back(e);
        step_model(i);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_tvalid = 2'b00;
    m_tready = 2'b11;
    for (int k = 0; k < 8 && (exp_l.size() + exp_r.size()) != 0; k++) cycle();
    n_cmp++;
    if (exp_l.size() != 0 || exp_r.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d/%0d samples outstanding, expected 0/0", exp_l.size(), exp_r.size());
    end
  endtask

  task automatic stream(int n, logic [1:0] vm, logic [1:0] rm);
    for (int k = 0; k < n; k++) begin
      s_l_tdata = $urandom;
      s_r_tdata = $urandom;
      s_tvalid  = vm;
      m_tready  = rm;
      cycle();
    end
    s_tvalid = 2'b00;
  endtask

  task automatic send_one(logic [1:0] vm, logic [31:0] dl, logic [31:0] dr,
                          logic [1:0] ov, logic [31:0] el, logic [31:0] er);
    s_l_tdata = dl;
    s_r_tdata = dr;
    ovr_v[0] = ov[0]; ovr_d[0] = el;
    ovr_v[1] = ov[1]; ovr_d[1] = er;
    s_tvalid = vm;
    m_tready = 2'b11;
    cycle();
    s_tvalid = 2'b00;
    ovr_v[0] = 1'b0;
    ovr_v[1] = 1'b0;
  endtask

  task automatic load_gain(logic [15:0] gl, logic [15:0] gr);
    gain_l = gl;
    gain_r = gr;
    gain_load = 1'b1;
    cycle();
    gain_load = 1'b0;
    cap[0] = int'($signed(gl));
    cap[1] = int'($signed(gr));
    repeat (3) cycle();
  endtask

  task automatic set_mute(logic v);
    mute = v;
    repeat (3) cycle();
  endtask

  task automatic model_reset();
    exp_l.delete();
    exp_r.delete();
    for (int i = 0; i < 2; i++) begin
      gm[i] = 16384; cap[i] = 16384; hold_v[i] = 1'b0; ovr_v[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 2'b00; m_tready = 2'b11;
    s_l_tdata = '0; s_r_tdata = '0;
    gain_l = 16'h4000; gain_r = 16'h4000; gain_load = 1'b0; mute = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (m_tvalid !== 2'b00) begin n_mis++; $display("FAIL rst_mvalid: got %b, expected 00", m_tvalid); end
    n_cmp++; if (s_tready !== 2'b00) begin n_mis++; $display("FAIL rst_sready: got %b, expected 00", s_tready); end
    n_cmp++; if (m_l_tdata !== 32'h0) begin n_mis++; $display("FAIL rst_ldata: got %h, expected 0", m_l_tdata); end
    n_cmp++; if (m_r_tdata !== 32'h0) begin n_mis++; $display("FAIL rst_rdata: got %h, expected 0", m_r_tdata); end
    rst = 1'b0;
    #1;
    n_cmp++; if (s_tready !== 2'b11) begin n_mis++; $display("FAIL post_rst_sready: got %b, expected 11", s_tready); end
  endtask

  task automatic test_unity();
    send_one(2'b11, 32'h0000_1234, 32'hFFFF_FFF0, 2'b11, 32'h0000_1234, 32'hFFFF_FFF0);
    n_cmp++; if (m_tvalid !== 2'b00) begin n_mis++; $display("FAIL lat1: m_tvalid %b, expected 00", m_tvalid); end
    cycle();
    n_cmp++; if (m_tvalid !== 2'b11) begin n_mis++; $display("FAIL lat2: m_tvalid %b, expected 11", m_tvalid); end
    drain();
  endtask

  task automatic test_half();
    load_gain(16'h2000, 16'h4000);
    stream(600, 2'b01, 2'b11);
    send_one(2'b01, 32'h0000_0003, 32'h0, 2'b01, 32'h0000_0002, 32'h0);
    send_one(2'b01, 32'hFFFF_FFFD, 32'h0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    drain();
  endtask

  task automatic test_saturate();
    load_gain(16'h7FFF, 16'h4000);
    stream(1600, 2'b11, 2'b11);
    send_one(2'b01, 32'h7FFF_FFFF, 32'h0, 2'b01, 32'h7FFF_FFFF, 32'h0);
    load_gain(16'h8000, 16'h4000);
    stream(4200, 2'b01, 2'b11);
    send_one(2'b01, 32'h7FFF_FFFF, 32'h0, 2'b01, 32'h8000_0000, 32'h0);
    drain();
  endtask

  task automatic test_ramp();
    logic [31:0] e;
    do_reset();
    load_gain(16'h3F00, 16'h4000);
    for (int k = 0; k < 20; k++) begin
      e = (k < 16) ? 32'h0000_4000 - 32'(16 * k) : 32'h0000_3F00;
      send_one(2'b01, 32'h0000_4000, 32'h0, 2'b01, e, 32'h0);
    end
    drain();
    set_mute(1'b1);
    for (int k = 0; k < 10; k++) begin
      e = 32'h0000_3F00 - 32'(16 * k);
      send_one(2'b11, 32'h0000_4000, 32'h0000_4000, 2'b01, e, 32'h0);
    end
    drain();
    set_mute(1'b0);
    stream(20, 2'b11, 2'b11);
    drain();
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      s_l_tdata = $urandom;
      s_r_tdata = $urandom;
      s_tvalid  = 2'b11;
      m_tready  = 2'b10;
      #1;
      if (c >= 2) begin
        n_cmp++; if (s_tready[0] !== 1'b0) begin n_mis++; $display("FAIL bp_l_ready c%0d: got %b, expected 0", c, s_tready[0]); end
      end
      n_cmp++; if (s_tready[1] !== 1'b1) begin n_mis++; $display("FAIL bp_r_ready c%0d: got %b, expected 1", c, s_tready[1]); end
      cycle();
    end
    stream(6, 2'b11, 2'b11);
    drain();
  endtask

  task automatic test_reset_midflight();
    stream(3, 2'b11, 2'b00);
    rst = 1'b1;
    #1;
    n_cmp++; if (m_tvalid !== 2'b00) begin n_mis++; $display("FAIL mid_rst_mvalid: got %b, expected 00", m_tvalid); end
    n_cmp++; if (s_tready !== 2'b00) begin n_mis++; $display("FAIL mid_rst_sready: got %b, expected 00", s_tready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (m_tvalid !== 2'b00) begin n_mis++; $display("FAIL after_rst_mvalid: got %b, expected 00", m_tvalid); end
    n_cmp++; if (s_tready !== 2'b11) begin n_mis++; $display("FAIL after_rst_sready: got %b, expected 11", s_tready); end
    send_one(2'b11, 32'h0000_4000, 32'h0000_4000, 2'b11, 32'h0000_4000, 32'h0000_4000);
    drain();
  endtask

  initial begin
    test_reset();
    test_unity();
    test_half();
    test_saturate();
    test_ramp();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
